// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: operation encoding and skid occupancy states.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOTB = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_COMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_skid.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid slot,
// registered in_ready so no combinational path runs from out_ready to in_ready.
module logic_unit_skid
  import logic_unit_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  state_e        state_reg, state_next;
  logic          in_ready_reg;
  logic [DW-1:0] out_data_reg;
  logic [DW-1:0] skid_data_reg;
  logic          in_fire, out_fire;
  logic          load_out_in, load_out_skid, load_skid;

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = out_data_reg;
  assign in_fire   = in_valid & in_ready_reg;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_next    = state_reg;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next  = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (in_fire && out_fire) begin
          load_out_in = 1'b1;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path can fire
        if (out_fire) begin
          state_next    = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      skid_data_reg <= '0;
    end else begin
      if (load_out_in) begin
        out_data_reg <= in_data;
      end else if (load_out_skid) begin
        out_data_reg <= skid_data_reg;
      end
      if (load_skid) begin
        skid_data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: op decode feeding a 2-entry skid buffer, plus a
// completed-transfer counter. Define LOGIC_UNIT_FLAGS_EN to add zero/parity outputs.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [CNT_W-1:0] txn_cnt
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int PW = 2 * WIDTH + 2;
`else
  localparam int PW = 2 * WIDTH;
`endif

  op_e              op_sel;
  logic [WIDTH-1:0] y1_c, y2_c;
  logic [PW-1:0]    din, dout;
  logic [CNT_W-1:0] txn_cnt_reg;

  assign op_sel = op_e'(op);

  always_comb begin
    y1_c = '0;
    case (op_sel)
      OP_AND:  y1_c = a & b;
      OP_OR:   y1_c = a | b;
      OP_XOR:  y1_c = a ^ b;
      OP_NOTB: y1_c = ~b;
      OP_NAND: y1_c = ~(a & b);
      OP_NOR:  y1_c = ~(a | b);
      OP_XNOR: y1_c = ~(a ^ b);
      OP_COMP: y1_c = c ^ (a & b);
      default: y1_c = '0;
    endcase
    // y2 is the complement of y1 except for the compound op
    y2_c = (op_sel == OP_COMP) ? ((a & b) | (c ^ ~b)) : ~y1_c;
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  assign din    = {y1_c, y2_c, (y1_c == '0), ^y1_c};
  assign zero   = dout[1];
  assign parity = dout[0];
`else
  assign din = {y1_c, y2_c};
`endif

  assign y1 = dout[PW-1 -: WIDTH];
  assign y2 = dout[PW-1-WIDTH -: WIDTH];

  logic_unit_skid #(
    .DW(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_reg <= '0;
    end else if (out_valid && out_ready) begin
      txn_cnt_reg <= txn_cnt_reg + CNT_W'(1);
    end
  end

  assign txn_cnt = txn_cnt_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8, CNT_W=4); follows LOGIC_UNIT_FLAGS_EN if defined.
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [7:0] y1;
    logic [7:0] y2;
    logic       z;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a, b, c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y1, y2;
  logic [3:0] txn_cnt;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic       zero, parity;
`endif

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  int   model_cnt = 0;
  int   out_fire_cnt = 0;
  int   in_acc_cnt = 0;
  bit   hold_prev = 0;
  logic [7:0] held_y1, held_y2;

  always #5 clk = ~clk;

  logic_unit_pipe #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y1       (y1),
    .y2       (y2),
    .txn_cnt  (txn_cnt)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .zero     (zero),
    .parity   (parity)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: each op written directly from its truth rule
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic [7:0] z);
    exp_t e;
    e.y1 = 8'h00;
    case (o)
      3'd0: e.y1 = x & y;
      3'd1: e.y1 = x | y;
      3'd2: e.y1 = x ^ y;
      3'd3: e.y1 = ~y;
      3'd4: e.y1 = ~(x & y);
      3'd5: e.y1 = ~(x | y);
      3'd6: e.y1 = ~(x ^ y);
      default: e.y1 = z ^ (x & y);
    endcase
    if (o == 3'd7) e.y2 = (x & y) | (z ^ ~y);
    else e.y2 = ~e.y1;
    e.z = (e.y1 == 8'h00);
    e.p = ($countones(e.y1) % 2) == 1;
    return e;
  endfunction

  // Monitor: owns the scoreboard, samples on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      hold_prev = 0;
    end else begin
      check("txn_cnt", {28'd0, txn_cnt}, model_cnt % 16);
      if (hold_prev && out_valid) begin
        check("hold_y1", {24'd0, y1}, {24'd0, held_y1});
        check("hold_y2", {24'd0, y2}, {24'd0, held_y2});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("y1", {24'd0, y1}, {24'd0, e.y1});
          check("y2", {24'd0, y2}, {24'd0, e.y2});
`ifdef LOGIC_UNIT_FLAGS_EN
          check("zero", {31'd0, zero}, {31'd0, e.z});
          check("parity", {31'd0, parity}, {31'd0, e.p});
`endif
        end
        model_cnt++;
        out_fire_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      held_y1 = y1;
      held_y2 = y2;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, a, b, c));
        in_acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] z);
    op = o; a = x; b = y; c = z;
  endtask

  // Offer a beat until accepted; returns 1 ns after the accepting edge with in_valid still high
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] z);
    int  n;
    bit  acc;
    set_beat(o, x, y, z);
    in_valid = 1'b1;
    n = 0;
    acc = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin
      step();
      n++;
    end
    if (out_valid) check("drain_timeout", 0, 1);
  endtask

  logic [7:0] ops_y1 [4];
  logic [2:0] ops_op [4];

  initial begin
    int base;
    logic [7:0] hy1;
    exp_t e;
    ops_op[0] = 3'd0; ops_y1[0] = 8'h48;
    ops_op[1] = 3'd2; ops_y1[1] = 8'h96;
    ops_op[2] = 3'd3; ops_y1[2] = 8'hA3;
    ops_op[3] = 3'd7; ops_y1[3] = 8'h47;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_beat(3'd0, 8'h00, 8'h00, 8'h00);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_txn_cnt", {28'd0, txn_cnt}, 0);
    check("rst_y1", {24'd0, y1}, 0);
    #20 rst_n = 1'b1;
    #1 check("in_ready_before_edge", {31'd0, in_ready}, 0);
    step();
    check("in_ready_after_release", {31'd0, in_ready}, 1);

    // every op with the reference operands, streamed
    out_ready = 1'b1;
    for (int o = 0; o < 8; o++) begin
      send(3'(o), 8'hCA, 8'h5C, 8'h0F);
      check("latency_out_valid", {31'd0, out_valid}, 1);
      e = model(3'(o), 8'hCA, 8'h5C, 8'h0F);
      check("op_y1_now", {24'd0, y1}, {24'd0, e.y1});
      for (int k = 0; k < 4; k++)
        if (ops_op[k] == 3'(o)) check("op_y1_vector", {24'd0, y1}, {24'd0, ops_y1[k]});
      if (o == 0) check("and_y2_vector", {24'd0, y2}, 32'hB7);
    end
    drain();

`ifdef LOGIC_UNIT_FLAGS_EN
    send(3'd0, 8'hF0, 8'h0F, 8'h00);
    check("flag_zero_and", {31'd0, zero}, 1);
    check("flag_parity_and", {31'd0, parity}, 0);
    send(3'd2, 8'h01, 8'h00, 8'h00);
    check("flag_zero_xor", {31'd0, zero}, 0);
    check("flag_parity_xor", {31'd0, parity}, 1);
    drain();
`endif

    // back-pressure: two beats fit, the third waits
    out_ready = 1'b0;
    base = in_acc_cnt;
    send(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom));
    send(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom));
    hy1 = y1;
    set_beat(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready_low", {31'd0, in_ready}, 0);
      check("bp_y1_stable", {24'd0, y1}, {24'd0, hy1});
    end
    check("bp_accepted", in_acc_cnt - base, 2);
    out_ready = 1'b1;
    send(op, a, b, c);
    drain();

    // streaming at full rate
    base = out_fire_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_beat(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom));
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", {31'd0, in_ready}, 1);
      if (i > 0) check("stream_out_valid", {31'd0, out_valid}, 1);
      step();
    end
    drain();
    check("stream_count", out_fire_cnt - base, 20);

    // random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      set_beat(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom));
      in_valid = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    drain();
    check("sb_empty_random", exp_q.size(), 0);

    // reset with two beats buffered
    out_ready = 1'b0;
    send(3'd1, 8'h11, 8'h22, 8'h33);
    send(3'd2, 8'h44, 8'h55, 8'h66);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 0);
    check("mid_rst_txn_cnt", {28'd0, txn_cnt}, 0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    check("mid_rst_in_ready_release", {31'd0, in_ready}, 1);

    // counter wrap after 17 transfers
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom));
    in_valid = 1'b0;
    step();
    check("txn_cnt_wrap", {28'd0, txn_cnt}, 1);
    drain();
    check("sb_empty_final", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
